// File: rtl/bin2onehot_pkg.sv
// Shared definitions for the registered binary-to-one-hot decoder.
// bin2onehot_f is also used by testbenches and encoder-side checkers.
package bin2onehot_pkg;

  localparam int MAX_WIDTH  = 8;
  localparam int MAX_ONEHOT = 2 ** MAX_WIDTH;

  // Callers narrow the result to their own 2**WIDTH vector; WIDTH must not exceed MAX_WIDTH.
  function automatic logic [MAX_ONEHOT-1:0] bin2onehot_f(input logic error,
                                                         input logic [MAX_WIDTH-1:0] bin);
    logic [MAX_ONEHOT-1:0] vec;
    vec = '0;
    if (!error) vec[bin] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/bin2onehot_reg_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main output register plus one skid
// register, with a registered in_ready and strict FIFO order.
module skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              skid_full
);

  logic              main_valid, main_valid_n;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic              skid_valid, skid_valid_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic              ready_q;
  logic              in_xfer;
  logic              main_free;

  assign in_xfer   = in_valid & ready_q;
  assign main_free = !main_valid | out_ready;

  // The skid entry always drains into main first, so a word accepted while
  // the skid is occupied must land behind it to keep FIFO order.
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (main_free) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = in_xfer;
        if (in_xfer) skid_data_n = in_data;
      end else begin
        main_valid_n = in_xfer;
        if (in_xfer) main_data_n = in_data;
      end
    end else if (in_xfer) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      ready_q    <= !skid_valid_n;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign skid_full = skid_valid;

endmodule

// File: rtl/bin2onehot_reg.sv
// Registered binary-to-one-hot decoder: decode {error,bin} then buffer in a skid_buf.
// Define BIN2ONEHOT_REG_ASSERT_EN to compile in the protocol/one-hot assertions.
module bin2onehot_reg
  import bin2onehot_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_error,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**WIDTH)-1:0] out_onehot,
  output logic                  out_error
);

  localparam int ONEHOT_W = 2 ** WIDTH;

  logic [ONEHOT_W-1:0] decoded;
  logic [ONEHOT_W:0]   out_payload;
  logic                skid_full;

  // Decoding before storage keeps the registered outputs free of decode logic.
  assign decoded = ONEHOT_W'(bin2onehot_f(in_error, MAX_WIDTH'(in_bin)));

  skid_buf #(
    .DATA_W (ONEHOT_W + 1)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_error, decoded}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload),
    .skid_full (skid_full)
  );

  assign out_error  = out_payload[ONEHOT_W];
  assign out_onehot = out_payload[ONEHOT_W-1:0];

`ifdef BIN2ONEHOT_REG_ASSERT_EN
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_error) |-> $onehot(out_onehot));

  a_error_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && out_error) |-> (out_onehot == '0));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_onehot) && $stable(out_error)));

  a_ready_skid: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && skid_full));

  a_no_x: assert property (@(posedge clk)
    rst_n |-> !$isunknown({out_valid, in_ready}));
`else
  // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_bin2onehot_reg.sv
// Scoreboard bench for bin2onehot_reg: stimulus pushes reference results,
// a negedge monitor pops and compares on every output transfer.
module tb_bin2onehot_reg;

  localparam int W  = 4;
  localparam int OW = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_error = 1'b0;
  logic [W-1:0]  in_bin = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_onehot;
  logic          out_error;

  bin2onehot_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_error   (in_error),
    .in_bin     (in_bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_error  (out_error)
  );

  always #5 clk = ~clk;

  logic [OW:0] expq[$];
  int nVec = 0;
  int nMis = 0;

  // Reference: {error, vector with only bit idx set, or nothing when error}.
  function automatic logic [OW:0] refModel(input logic err, input int idx);
    logic [OW-1:0] v;
    v = '0;
    if (!err)
      for (int i = 0; i < OW; i++)
        if (i == idx) v[i] = 1'b1;
    return {err, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic err, input logic [W-1:0] bin, output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    in_valid = 1'b1;
    in_error = err;
    in_bin   = bin;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      cycles++;
      if (in_ready) begin
        expq.push_back(refModel(err, int'(bin)));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      nVec++;
      nMis++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && expq.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Monitor: compares each output transfer and checks stability under back-pressure.
  logic        prevHold = 1'b0;
  logic [OW:0] prevData = '0;
  logic [OW:0] expWord;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'({out_error, out_onehot}), 32'(prevData));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          nVec++;
          nMis++;
          $display("[TB] FAIL unexpected_output: got %h expected no word", {out_error, out_onehot});
        end else begin
          expWord = expq.pop_front();
          checkOutput("sb_data", 32'({out_error, out_onehot}), 32'(expWord));
        end
      end
      prevHold = out_valid && !out_ready;
      prevData = {out_error, out_onehot};
    end
  end

  int  cyc;
  bit  holding;

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_onehot", 32'(out_onehot), 32'd0);
    checkOutput("rst_error", 32'(out_error), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_first_cycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_after_release", 32'(in_ready), 32'd1);
    checkOutput("valid_after_release", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd5, cyc);
    @(negedge clk);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_onehot", 32'(out_onehot), 32'h0020);
    checkOutput("single_error", 32'(out_error), 32'd0);
    @(posedge clk); #1;

    applyStimulus(1'b1, 4'd7, cyc);
    @(negedge clk);
    checkOutput("err_onehot", 32'(out_onehot), 32'h0000);
    checkOutput("err_error", 32'(out_error), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < OW; i++) begin
      applyStimulus(1'b0, W'(i), cyc);
      checkOutput("sweep_rate", 32'(cyc), 32'd1);
    end
    drain();

    out_ready = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd3, cyc);
    applyStimulus(1'b0, 4'd9, cyc);
    in_valid = 1'b1;
    in_error = 1'b0;
    in_bin   = 4'd12;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_main", 32'(out_onehot), 32'h0008);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd12, cyc);
    drain();

    holding = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!holding) begin
        in_valid = ($urandom % 4) != 0;
        in_error = ($urandom % 8) == 0;
        in_bin   = W'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        expq.push_back(refModel(in_error, int'(in_bin)));
        holding = 1'b0;
      end else begin
        holding = in_valid;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd1, cyc);
    applyStimulus(1'b0, 4'd2, cyc);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_onehot", 32'(out_onehot), 32'd0);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd10, cyc);
    @(negedge clk);
    checkOutput("post_rst_onehot", 32'(out_onehot), 32'h0400);
    @(posedge clk); #1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
